// File: rtl/nf10_packet_rr_arbiter.sv
// nf10_packet_rr_arbiter: packet-granular round-robin arbiter merging NUM_INPUTS AXI-Stream inputs onto one master.
module nf10_packet_rr_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_INPUTS           = 5
) (
  input  logic                                         axi_aclk,
  input  logic                                         axi_resetn,
  input  logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [NUM_INPUTS*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_INPUTS-1:0]                        s_axis_tvalid,
  input  logic [NUM_INPUTS-1:0]                        s_axis_tlast,
  output logic [NUM_INPUTS-1:0]                        s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]             m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]              m_axis_tuser,
  output logic                                         m_axis_tvalid,
  output logic                                         m_axis_tlast,
  input  logic                                         m_axis_tready,
  output logic [$clog2(NUM_INPUTS)-1:0]                grant_idx,
  output logic [NUM_INPUTS*32-1:0]                     pkt_count
);
  localparam int N  = NUM_INPUTS;
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int IW = $clog2(NUM_INPUTS);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, grant_q, grant_d, pick, scan;
  logic [N-1:0][31:0] cnt_q;
  logic found, in_pkt, done;
  logic [DW-1:0] data_a [N];
  logic [SW-1:0] strb_a [N];
  logic [UW-1:0] user_a [N];
  for (genvar k = 0; k < N; k++) begin : g_in
    assign data_a[k] = s_axis_tdata[k*DW +: DW];
    assign strb_a[k] = s_axis_tstrb[k*SW +: SW];
    assign user_a[k] = s_axis_tuser[k*UW +: UW];
  end
  // first valid input after the last-served one, wrapping modulo N
  always_comb begin
    pick = rr_q;
    scan = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      scan = IW'((int'(rr_q) + i) % N);
      if (!found && s_axis_tvalid[scan]) begin
        pick = scan;
        found = 1'b1;
      end
    end
  end
  assign in_pkt        = state_q == PKT;
  assign m_axis_tdata  = data_a[grant_q];
  assign m_axis_tstrb  = strb_a[grant_q];
  assign m_axis_tuser  = user_a[grant_q];
  assign m_axis_tvalid = in_pkt && s_axis_tvalid[grant_q];
  assign m_axis_tlast  = in_pkt && s_axis_tlast[grant_q];
  assign s_axis_tready = in_pkt ? (N'(m_axis_tready) << grant_q) : '0;
  assign done          = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign state_d       = in_pkt ? (done ? IDLE : PKT) : (found ? PKT : IDLE);
  assign rr_d          = (!in_pkt && found) ? pick : rr_q;
  assign grant_d       = (!in_pkt && found) ? pick : grant_q;
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      rr_q    <= IW'(N - 1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      if (done) cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
    end
  end
  assign grant_idx = grant_q;
  assign pkt_count = cnt_q;
endmodule

// File: doc/nf10_packet_rr_arbiter.md
NF10_PACKET_RR_ARBITER -- requirements
Module: nf10_packet_rr_arbiter

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, per-input data width.
REQ-002 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, output data width; SHALL equal C_S_AXIS_DATA_WIDTH.
REQ-003 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, per-input tuser width.
REQ-004 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128, output tuser width; SHALL equal C_S_AXIS_TUSER_WIDTH.
REQ-005 SHALL have parameter NUM_INPUTS, default 5, number of requesters, range 2..8.
REQ-006 SHALL have axi_aclk, input, 1, sole clock, all state on rising edge.
REQ-007 SHALL have axi_resetn, input, 1; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have s_axis_tdata, input, NUM_INPUTS*C_S_AXIS_DATA_WIDTH; input k at slice k.
REQ-009 SHALL have s_axis_tstrb, input, NUM_INPUTS*C_S_AXIS_DATA_WIDTH/8; per-input byte strobes.
REQ-010 SHALL have s_axis_tuser, input, NUM_INPUTS*C_S_AXIS_TUSER_WIDTH; per-input metadata.
REQ-011 SHALL have s_axis_tvalid, input, NUM_INPUTS; s_axis_tlast, input, NUM_INPUTS; s_axis_tready, output, NUM_INPUTS.
REQ-012 SHALL have m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast as outputs and m_axis_tready as input; single AXI-Stream master toward the output-queue slave port.
REQ-013 SHALL have grant_idx, output, log2(NUM_INPUTS); index of currently or last granted input.
REQ-014 SHALL have pkt_count, output, NUM_INPUTS*32; per-input count of forwarded packets.

Function
REQ-015 SHALL implement states IDLE and PKT, state register plus rr_ptr (last-served index).
REQ-016 IDLE: m_axis_tvalid=0, all s_axis_tready=0; if any s_axis_tvalid set, SHALL select first set index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_INPUTS, register it into grant_idx and rr_ptr, go to PKT next cycle.
REQ-017 IDLE with no s_axis_tvalid set SHALL remain IDLE, grant_idx and rr_ptr unchanged.
REQ-018 PKT: m_axis_tdata/tstrb/tuser/tlast/tvalid SHALL combinationally equal slice grant_idx of inputs; s_axis_tready[grant_idx]=m_axis_tready; all other s_axis_tready=0.
REQ-019 PKT: beat transfers only when m_axis_tvalid and m_axis_tready both 1; SHALL return to IDLE the cycle after the beat with tlast=1 transfers.
REQ-020 Grant SHALL never change inside a packet; tvalid deassertion or tready backpressure mid-packet SHALL hold PKT indefinitely.
REQ-021 Latency: first beat earliest one cycle after tvalid seen in IDLE; exactly one idle bubble cycle between consecutive packets.
REQ-022 Single-beat packet (tvalid and tlast together) SHALL be forwarded in one PKT cycle.
REQ-023 pkt_count[k] SHALL increment by 1 on each transferred tlast beat of input k, 32-bit, wrap 0xFFFFFFFF->0.
REQ-024 Fairness: with all inputs continuously valid, each input SHALL be granted once per NUM_INPUTS packets, order rr_ptr+1 onward.
REQ-025 Inputs not granted SHALL see tready=0 and SHALL NOT lose data.

Reset
REQ-026 axi_resetn=0 SHALL immediately force state=IDLE, rr_ptr=NUM_INPUTS-1, grant_idx=0, pkt_count all 0, m_axis_tvalid=0, all s_axis_tready=0, independent of clock.
REQ-027 Reset mid-packet SHALL truncate the packet; no count incremented; after release, first grant SHALL go to lowest-index valid input.
REQ-028 Reset release SHALL be sampled synchronously; first arbitration on first rising edge with axi_resetn=1.

Verification
REQ-029 Reset, then input 2 only sends 3-beat packet, m_axis_tready=1 -> grant_idx=2, beats out on cycles 2-4, pkt_count[2]=1, IDLE cycle 5.
REQ-030 All 5 inputs valid with 1-beat packets, 10 packets -> grant order 0,1,2,3,4,0,1,2,3,4, each pkt_count=2, one bubble between packets.
REQ-031 Input 1 4-beat packet, m_axis_tready low on beats 2 and 3 for 3 cycles each -> data held stable, s_axis_tready[1] mirrors m_axis_tready, no other tready asserted, grant unchanged.
REQ-032 Input 0 mid-packet tvalid drops 5 cycles while input 3 valid -> grant stays 0 until input 0 tlast, then input 3 granted.
REQ-033 Assert axi_resetn=0 between clock edges during beat 2 of 4 -> m_axis_tvalid=0 same instant, pkt_count unchanged at 0, after release lowest valid index granted.
REQ-034 Preload via 2^32-1 packets on input 4 (or forced counter) then one more -> pkt_count[4]=0.
